// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and defaults for the instruction-fetch stage
package if_pkg;

  localparam int              IF_ADDR_W    = 16;
  localparam int              IF_INSTR_W   = 16;
  localparam logic [15:0]     IF_RESET_PC  = 16'h0000;
  localparam logic [15:0]     IF_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_perf.sv
// rtl/if_fetch_perf.sv - saturating hit/miss counters for the fetch stage
module if_fetch_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (hit_inc && (r_hit_cnt != 16'hFFFF))
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (miss_inc && (r_miss_cnt != 16'hFFFF))
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, I-cache lookup, miss refill FSM
// Optional IF_FETCH_PERF_EN adds hit_cnt/miss_cnt outputs.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                   ADDR_W    = IF_ADDR_W,
  parameter int                   INSTR_W   = IF_INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC  = ADDR_W'(IF_RESET_PC),
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(IF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  cache_addr,
  input  logic               cache_hit,
  input  logic [INSTR_W-1:0] cache_instr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic               fill_valid,
  output logic [ADDR_W-1:0]  fill_addr,
  output logic [INSTR_W-1:0] fill_data,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               hit_fetch_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_redir_pend;
  logic [INSTR_W-1:0] r_buf;
  logic               r_mem_req;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_fill_valid;
  logic [ADDR_W-1:0]  r_fill_addr;
  logic [INSTR_W-1:0] r_fill_data;
  logic [ADDR_W-1:0]  r_addr_out;
  logic [INSTR_W-1:0] r_instr_out;
  logic               r_hit_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_buf        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_data  <= '0;
      r_addr_out   <= RESET_PC;
      r_instr_out  <= NOP_INSTR;
      r_hit_fetch  <= 1'b0;
    end else begin
      r_fill_valid <= 1'b0;
      case (r_state)
        RUN: begin
          if (redirect_valid) begin
            r_pc        <= redirect_addr;
            r_addr_out  <= redirect_addr;
            r_instr_out <= NOP_INSTR;
            r_hit_fetch <= 1'b0;
          end else if (!stall) begin
            if (cache_hit) begin
              r_addr_out  <= r_pc;
              r_instr_out <= cache_instr;
              r_hit_fetch <= 1'b1;
              r_pc        <= r_pc + ADDR_W'(1);
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_addr  <= r_pc;
              r_addr_out  <= r_pc;
              r_instr_out <= NOP_INSTR;
              r_hit_fetch <= 1'b0;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          // The handshake always completes; a redirect only retargets the PC
          // and marks the returning word as not-to-be-delivered.
          if (redirect_valid) begin
            r_redir_pend <= 1'b1;
            r_pc         <= redirect_addr;
          end
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_fill_valid <= 1'b1;
            r_fill_addr  <= r_mem_addr;
            r_fill_data  <= mem_data;
            r_buf        <= mem_data;
            if (r_redir_pend || redirect_valid) begin
              r_redir_pend <= 1'b0;
              r_state      <= RUN;
            end else begin
              r_state <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (redirect_valid) begin
            r_pc        <= redirect_addr;
            r_addr_out  <= redirect_addr;
            r_instr_out <= NOP_INSTR;
            r_hit_fetch <= 1'b0;
            r_state     <= RUN;
          end else if (!stall) begin
            r_addr_out  <= r_pc;
            r_instr_out <= r_buf;
            r_hit_fetch <= 1'b0;
            r_pc        <= r_pc + ADDR_W'(1);
            r_state     <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign cache_addr    = r_pc;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign fill_valid    = r_fill_valid;
  assign fill_addr     = r_fill_addr;
  assign fill_data     = r_fill_data;
  assign addr_out      = r_addr_out;
  assign instr_out     = r_instr_out;
  assign hit_fetch_out = r_hit_fetch;

`ifdef IF_FETCH_PERF_EN
  logic w_fetch_go;
  assign w_fetch_go = (r_state == RUN) && !redirect_valid && !stall;

  if_fetch_perf u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .hit_inc  (w_fetch_go && cache_hit),
    .miss_inc (w_fetch_go && !cache_hit),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic [15:0] cache_addr;
  logic        cache_hit;
  logic [15:0] cache_instr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        fill_valid;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic [15:0] addr_out;
  logic [15:0] instr_out;
  logic        hit_fetch_out;
`ifdef IF_FETCH_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .cache_addr     (cache_addr),
    .cache_hit      (cache_hit),
    .cache_instr    (cache_instr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .fill_valid     (fill_valid),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .addr_out       (addr_out),
    .instr_out      (instr_out),
    .hit_fetch_out  (hit_fetch_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        r;
    logic [15:0] ra;
    logic        h;
    logic [15:0] ci;
    logic [15:0] ea;
    logic [15:0] ei;
    logic        eh;
    logic [15:0] epc;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] i;
    logic        h;
  } out_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t sb_q[$];
  vec_t tbl[14];

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] ra,
                              input logic h, input logic [15:0] ci, input logic [15:0] ea,
                              input logic [15:0] ei, input logic eh, input logic [15:0] epc);
    vec_t v;
    v.s = s; v.r = r; v.ra = ra; v.h = h; v.ci = ci;
    v.ea = ea; v.ei = ei; v.eh = eh; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic r, input logic [15:0] ra, input logic h,
                        input logic [15:0] ci, input logic ack, input logic [15:0] md);
    stall = s; redirect_valid = r; redirect_addr = ra;
    cache_hit = h; cache_instr = ci; mem_ack = ack; mem_data = md;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] i, input logic h);
    out_t o;
    o.a = a; o.i = i; o.h = h;
    sb_q.push_back(o);
  endtask

  task automatic pop_chk(input string tag);
    out_t o;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      o = sb_q.pop_front();
      chk({tag, ".addr_out"}, {16'h0, addr_out}, {16'h0, o.a});
      chk({tag, ".instr_out"}, {16'h0, instr_out}, {16'h0, o.i});
      chk({tag, ".hit_fetch"}, {31'h0, hit_fetch_out}, {31'h0, o.h});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    tick(); tick();
    chk("rst.addr_out", {16'h0, addr_out}, 32'h0);
    chk("rst.instr_out", {16'h0, instr_out}, 32'h0);
    chk("rst.hit_fetch", {31'h0, hit_fetch_out}, 32'h0);
    chk("rst.mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst.fill_valid", {31'h0, fill_valid}, 32'h0);
    chk("rst.pc", {16'h0, cache_addr}, 32'h0);
    rst_n = 1'b1;

    // s  r  ra       h  ci        ea       ei       eh epc
    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'hA000, 16'h0000, 16'hA000, 1, 16'h0001);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'hA001, 16'h0001, 16'hA001, 1, 16'h0002);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'hA002, 16'h0002, 16'hA002, 1, 16'h0003);
    tbl[3]  = mk(0, 0, 16'h0000, 1, 16'hA003, 16'h0003, 16'hA003, 1, 16'h0004);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 16'hA004, 16'h0004, 16'hA004, 1, 16'h0005);
    tbl[5]  = mk(1, 0, 16'h0000, 1, 16'hA005, 16'h0004, 16'hA004, 1, 16'h0005);
    tbl[6]  = mk(1, 0, 16'h0000, 1, 16'hA005, 16'h0004, 16'hA004, 1, 16'h0005);
    tbl[7]  = mk(1, 0, 16'h0000, 1, 16'hA005, 16'h0004, 16'hA004, 1, 16'h0005);
    tbl[8]  = mk(1, 0, 16'h0000, 1, 16'hA005, 16'h0004, 16'hA004, 1, 16'h0005);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 16'hA005, 16'h0005, 16'hA005, 1, 16'h0006);
    tbl[10] = mk(1, 1, 16'hFFFF, 1, 16'hA006, 16'hFFFF, 16'h0000, 0, 16'hFFFF);
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'hBEEF, 16'hFFFF, 16'hBEEF, 1, 16'h0000);
    tbl[12] = mk(0, 0, 16'h0000, 1, 16'hA000, 16'h0000, 16'hA000, 1, 16'h0001);
    tbl[13] = mk(0, 1, 16'h0010, 0, 16'h0000, 16'h0010, 16'h0000, 0, 16'h0010);

    for (int k = 0; k < 14; k++) begin
      set_in(tbl[k].s, tbl[k].r, tbl[k].ra, tbl[k].h, tbl[k].ci, 0, 16'h0);
      push_exp(tbl[k].ea, tbl[k].ei, tbl[k].eh);
      tick();
      pop_chk($sformatf("vec%0d", k));
      chk($sformatf("vec%0d.pc", k), {16'h0, cache_addr}, {16'h0, tbl[k].epc});
      chk($sformatf("vec%0d.mem_req", k), {31'h0, mem_req}, 32'h0);
      chk($sformatf("vec%0d.fill_valid", k), {31'h0, fill_valid}, 32'h0);
    end

    // Miss at 0x0010, ack on the fourth cycle, stall held during DELIVER
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    push_exp(16'h0010, 16'h0000, 0);
    tick();
    pop_chk("miss.bubble");
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("miss.req%0d", k), {31'h0, mem_req}, 32'h1);
      chk($sformatf("miss.addr%0d", k), {16'h0, mem_addr}, 32'h0010);
      chk($sformatf("miss.nofill%0d", k), {31'h0, fill_valid}, 32'h0);
      if (k < 2) begin
        set_in(1, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        tick();
      end
    end
    set_in(0, 0, 16'h0, 0, 16'h0, 1, 16'h1234);
    tick();
    chk("miss.fill_valid", {31'h0, fill_valid}, 32'h1);
    chk("miss.fill_addr", {16'h0, fill_addr}, 32'h0010);
    chk("miss.fill_data", {16'h0, fill_data}, 32'h1234);
    chk("miss.req_drop", {31'h0, mem_req}, 32'h0);
    chk("miss.still_bubble", {16'h0, instr_out}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, 16'h0, 0, 16'h0, 1, 16'h9999);
      tick();
      chk($sformatf("dlv.stall_fill%0d", k), {31'h0, fill_valid}, 32'h0);
      chk($sformatf("dlv.stall_instr%0d", k), {16'h0, instr_out}, 32'h0);
    end
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    push_exp(16'h0010, 16'h1234, 0);
    tick();
    pop_chk("dlv.out");
    chk("dlv.pc", {16'h0, cache_addr}, 32'h0011);

    // Redirect during REQ: fill completes, 0x0010 is not delivered
    set_in(0, 1, 16'h0010, 0, 16'h0, 0, 16'h0);
    push_exp(16'h0010, 16'h0000, 0);
    tick();
    pop_chk("rdq.redir");
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    tick();
    chk("rdq.req", {31'h0, mem_req}, 32'h1);
    set_in(0, 1, 16'h0200, 0, 16'h0, 0, 16'h0);
    tick();
    chk("rdq.req_held", {31'h0, mem_req}, 32'h1);
    chk("rdq.addr_held", {16'h0, mem_addr}, 32'h0010);
    chk("rdq.pc", {16'h0, cache_addr}, 32'h0200);
    set_in(0, 0, 16'h0, 0, 16'h0, 1, 16'h5555);
    tick();
    chk("rdq.fill_valid", {31'h0, fill_valid}, 32'h1);
    chk("rdq.fill_addr", {16'h0, fill_addr}, 32'h0010);
    chk("rdq.fill_data", {16'h0, fill_data}, 32'h5555);
    chk("rdq.req_drop", {31'h0, mem_req}, 32'h0);
    chk("rdq.no_deliver", {16'h0, instr_out}, 32'h0);
    set_in(0, 0, 16'h0, 1, 16'h7777, 1, 16'h1111);
    push_exp(16'h0200, 16'h7777, 1);
    tick();
    pop_chk("rdq.hit");
    chk("rdq.fill_once", {31'h0, fill_valid}, 32'h0);
    chk("rdq.pc_next", {16'h0, cache_addr}, 32'h0201);

    // Asynchronous reset in the middle of REQ
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    tick();
    chk("arst.req", {31'h0, mem_req}, 32'h1);
    chk("arst.req_addr", {16'h0, mem_addr}, 32'h0201);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.mem_req", {31'h0, mem_req}, 32'h0);
    chk("arst.mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("arst.addr_out", {16'h0, addr_out}, 32'h0);
    chk("arst.instr_out", {16'h0, instr_out}, 32'h0);
    chk("arst.hit", {31'h0, hit_fetch_out}, 32'h0);
    chk("arst.pc", {16'h0, cache_addr}, 32'h0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 16'h0, 1, 16'hC000 + 16'(k), 0, 16'h0);
      push_exp(16'(k), 16'hC000 + 16'(k), 1);
      tick();
      pop_chk($sformatf("post%0d", k));
    end
    set_in(0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    tick();
    chk("post.miss_req", {31'h0, mem_req}, 32'h1);
    chk("post.miss_addr", {16'h0, mem_addr}, 32'h0003);
`ifdef IF_FETCH_PERF_EN
    chk("perf.hit_cnt", {16'h0, hit_cnt}, 32'h3);
    chk("perf.miss_cnt", {16'h0, miss_cnt}, 32'h1);
`endif
    set_in(0, 0, 16'h0, 0, 16'h0, 1, 16'hABCD);
    tick();
    chk("post.fill", {31'h0, fill_valid}, 32'h1);
    chk("post.fill_data", {16'h0, fill_data}, 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
